// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, SR/Cause field positions and bus widths.
package cp0_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned PC_W    = 30;
    localparam int unsigned HWINT_W = 6;

    localparam int unsigned REG_SR    = 12;
    localparam int unsigned REG_CAUSE = 13;
    localparam int unsigned REG_EPC   = 14;
    localparam int unsigned REG_PRID  = 15;

    localparam int unsigned IM_HI   = 15;
    localparam int unsigned IM_LO   = 10;
    localparam int unsigned EXL_BIT = 1;
    localparam int unsigned IE_BIT  = 0;

    localparam int unsigned IM_W = IM_HI - IM_LO + 1;

endpackage

// File: rtl/cp0_int_gen.sv
// Interrupt request reduction: any pending unmasked line, globally enabled, not in service.
module cp0_int_gen
    import cp0_pkg::*;
(
    input  logic [IM_W-1:0] ip,
    input  logic [IM_W-1:0] im,
    input  logic            ie,
    input  logic            exl,
    output logic            int_req
);

    assign int_req = (|(ip & im)) & ie & ~exl;

endmodule

// File: rtl/cp0_intc.sv
// CP0 interrupt controller: SR/Cause/EPC/PRId registers, mtc0/mfc0 access and eret/EXL handling.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID = 32'h0000_2015
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HWINT_W-1:0]  hwint,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                we,
    input  logic [DATA_W-1:0]   din,
    output logic [DATA_W-1:0]   dout,
    input  logic [PC_W-1:0]     pc,
    input  logic                exl_set,
    input  logic                exl_clr,
    output logic                int_req,
    output logic [DATA_W-1:0]   epc
);

    logic [IM_W-1:0] im_q;
    logic [IM_W-1:0] ip_q;
    logic            exl_q;
    logic            ie_q;
    logic [PC_W-1:0] epc_q;

    logic wr_sr;
    logic wr_epc;

    assign wr_sr  = we && (addr == ADDR_W'(REG_SR));
    assign wr_epc = we && (addr == ADDR_W'(REG_EPC));

    // IP follows the request lines every edge; peripherals hold requests until serviced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ip_q <= '0;
        end else begin
            ip_q <= hwint;
        end
    end

    // IM/IE are plain SR fields; pipeline strobes never block them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            im_q <= '0;
            ie_q <= 1'b0;
        end else if (wr_sr) begin
            im_q <= din[IM_HI:IM_LO];
            ie_q <= din[IE_BIT];
        end
    end

    // EXL priority: interrupt entry, then eret, then software write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exl_q <= 1'b0;
        end else if (exl_set) begin
            exl_q <= 1'b1;
        end else if (exl_clr) begin
            exl_q <= 1'b0;
        end else if (wr_sr) begin
            exl_q <= din[EXL_BIT];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q <= '0;
        end else if (exl_set) begin
            epc_q <= pc;
        end else if (wr_epc) begin
            epc_q <= din[DATA_W-1:2];
        end
    end

    assign epc = {epc_q, 2'b00};

    // mfc0 read mux; unlisted register numbers read as zero.
    always_comb begin
        dout = '0;
        case (addr)
            ADDR_W'(REG_SR): begin
                dout[IM_HI:IM_LO] = im_q;
                dout[EXL_BIT]     = exl_q;
                dout[IE_BIT]      = ie_q;
            end
            ADDR_W'(REG_CAUSE): dout[IM_HI:IM_LO] = ip_q;
            ADDR_W'(REG_EPC):   dout = {epc_q, 2'b00};
            ADDR_W'(REG_PRID):  dout = PRID;
            default:            dout = '0;
        endcase
    end

    cp0_int_gen u_int_gen (
        .ip      (ip_q),
        .im      (im_q),
        .ie      (ie_q),
        .exl     (exl_q),
        .int_req (int_req)
    );

endmodule

// File: tb/tb_cp0_intc.sv
// Self-checking bench for cp0_intc: directed vector table, corner sequences and random run against a word-level model.
module tb_cp0_intc;

    logic        clk;
    logic        reset;
    logic [5:0]  hwint;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic [29:0] pc;
    logic        exl_set;
    logic        exl_clr;
    logic        int_req;
    logic [31:0] epc;

    int n_pass;
    int n_total;

    // Model: SR kept as a whole 32-bit word, Cause IP bits, EPC word.
    logic [31:0] m_sr;
    logic [5:0]  m_ip;
    logic [31:0] m_epc;

    localparam logic [31:0] PRID_V = 32'h0000_2015;

    cp0_intc dut (
        .clk     (clk),
        .reset   (reset),
        .hwint   (hwint),
        .addr    (addr),
        .we      (we),
        .din     (din),
        .dout    (dout),
        .pc      (pc),
        .exl_set (exl_set),
        .exl_clr (exl_clr),
        .int_req (int_req),
        .epc     (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  hw;
        logic [4:0]  a;
        logic        w;
        logic [31:0] d;
        logic [29:0] p;
        logic        s;
        logic        c;
        logic [4:0]  ra;
        logic        ei;
        logic [31:0] ed;
        logic [31:0] ee;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_sr  = '0;
        m_ip  = '0;
        m_epc = '0;
    endtask

    task automatic model_edge(input logic [5:0] hw, input logic [4:0] a, input logic w,
                              input logic [31:0] d, input logic [29:0] p, input logic s, input logic c);
        logic [31:0] nsr;
        nsr = m_sr;
        if (w && a == 5'd12) nsr = d & 32'h0000_FC03;
        if (s)      nsr[1] = 1'b1;
        else if (c) nsr[1] = 1'b0;
        if (s)                     m_epc = {p, 2'b00};
        else if (w && a == 5'd14)  m_epc = d & 32'hFFFF_FFFC;
        m_sr = nsr;
        m_ip = hw;
    endtask

    function automatic logic model_int();
        return ((m_ip & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return {16'd0, m_ip, 10'd0};
            5'd14:   return m_epc;
            5'd15:   return PRID_V;
            default: return 32'd0;
        endcase
    endfunction

    // One clocked cycle: inputs held across the edge, strobes dropped #1 after it.
    task automatic cycle(input logic [5:0] hw, input logic [4:0] a, input logic w,
                         input logic [31:0] d, input logic [29:0] p, input logic s, input logic c);
        hwint = hw; addr = a; we = w; din = d; pc = p; exl_set = s; exl_clr = c;
        @(posedge clk);
        model_edge(hw, a, w, d, p, s, c);
        #1;
        we = 1'b0; exl_set = 1'b0; exl_clr = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, dout, exp);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; hwint = '0; addr = '0; we = 1'b0; din = '0; pc = '0;
        exl_set = 1'b0; exl_clr = 1'b0;
        model_reset();

        vecs[0]  = '{6'h00, 5'd12, 1'b1, 32'h0000_0401, 30'h0, 1'b0, 1'b0, 5'd12, 1'b0, 32'h0000_0401, 32'h0};
        vecs[1]  = '{6'h01, 5'd0,  1'b0, 32'h0,         30'h0, 1'b0, 1'b0, 5'd13, 1'b1, 32'h0000_0400, 32'h0};
        vecs[2]  = '{6'h00, 5'd0,  1'b0, 32'h0,         30'h0, 1'b0, 1'b0, 5'd13, 1'b0, 32'h0000_0000, 32'h0};
        vecs[3]  = '{6'h01, 5'd12, 1'b1, 32'h0000_0801, 30'h0, 1'b0, 1'b0, 5'd12, 1'b0, 32'h0000_0801, 32'h0};
        vecs[4]  = '{6'h01, 5'd0,  1'b0, 32'h0,         30'h0, 1'b0, 1'b0, 5'd13, 1'b0, 32'h0000_0400, 32'h0};
        vecs[5]  = '{6'h01, 5'd12, 1'b1, 32'h0000_0400, 30'h0, 1'b0, 1'b0, 5'd12, 1'b0, 32'h0000_0400, 32'h0};
        vecs[6]  = '{6'h01, 5'd12, 1'b1, 32'h0000_0401, 30'h0, 1'b0, 1'b0, 5'd12, 1'b1, 32'h0000_0401, 32'h0};
        vecs[7]  = '{6'h01, 5'd0,  1'b0, 32'h0, 30'h0000_0C02, 1'b1, 1'b0, 5'd12, 1'b0, 32'h0000_0403, 32'h0000_3008};
        vecs[8]  = '{6'h01, 5'd0,  1'b0, 32'h0,         30'h0, 1'b0, 1'b0, 5'd14, 1'b0, 32'h0000_3008, 32'h0000_3008};
        vecs[9]  = '{6'h01, 5'd0,  1'b0, 32'h0,         30'h0, 1'b0, 1'b1, 5'd12, 1'b1, 32'h0000_0401, 32'h0000_3008};
        vecs[10] = '{6'h01, 5'd14, 1'b1, 32'h0000_1234, 30'h0000_0C02, 1'b1, 1'b0, 5'd14, 1'b0, 32'h0000_3008, 32'h0000_3008};
        vecs[11] = '{6'h01, 5'd14, 1'b1, 32'h0000_1237, 30'h0, 1'b0, 1'b1, 5'd14, 1'b1, 32'h0000_1234, 32'h0000_1234};
        vecs[12] = '{6'h01, 5'd0,  1'b0, 32'h0, 30'h0000_0100, 1'b1, 1'b1, 5'd12, 1'b0, 32'h0000_0403, 32'h0000_0400};
        vecs[13] = '{6'h01, 5'd12, 1'b1, 32'hFFFF_FFFF, 30'h0, 1'b0, 1'b1, 5'd12, 1'b1, 32'h0000_FC01, 32'h0000_0400};
        vecs[14] = '{6'h01, 5'd15, 1'b1, 32'h0000_0000, 30'h0, 1'b0, 1'b0, 5'd15, 1'b1, 32'h0000_2015, 32'h0000_0400};
        vecs[15] = '{6'h22, 5'd13, 1'b1, 32'hFFFF_FFFF, 30'h0, 1'b0, 1'b0, 5'd13, 1'b1, 32'h0000_8800, 32'h0000_0400};
        vecs[16] = '{6'h00, 5'd7,  1'b1, 32'hFFFF_FFFF, 30'h0, 1'b0, 1'b0, 5'd7,  1'b0, 32'h0000_0000, 32'h0000_0400};
        vecs[17] = '{6'h01, 5'd12, 1'b1, 32'h0000_0403, 30'h0, 1'b0, 1'b0, 5'd12, 1'b0, 32'h0000_0403, 32'h0000_0400};

        // Random prior state, then async reset away from the edge.
        #12 reset = 1'b0;
        for (int i = 0; i < 20; i++)
            cycle(6'($urandom), 5'(11 + $urandom_range(0, 4)), 1'($urandom), $urandom, 30'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("reset_int_req", 32'(int_req), 32'd0);
        check("reset_epc", epc, 32'd0);
        read_check("reset_sr", 5'd12, 32'd0);
        read_check("reset_cause", 5'd13, 32'd0);
        read_check("reset_epc_reg", 5'd14, 32'd0);
        read_check("reset_prid", 5'd15, PRID_V);
        @(posedge clk); #1 reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            cycle(vecs[i].hw, vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].p, vecs[i].s, vecs[i].c);
            check($sformatf("vec%0d_int_req", i), 32'(int_req), 32'(vecs[i].ei));
            check($sformatf("vec%0d_epc", i), epc, vecs[i].ee);
            read_check($sformatf("vec%0d_dout", i), vecs[i].ra, vecs[i].ed);
        end

        // mtc0 is not visible on dout before its edge.
        hwint = 6'h00; addr = 5'd12; we = 1'b1; din = 32'h0000_0C01;
        #1;
        check("no_bypass_pre", dout, 32'h0000_0403);
        cycle(6'h00, 5'd12, 1'b1, 32'h0000_0C01, 30'h0, 1'b0, 1'b0);
        read_check("no_bypass_post", 5'd12, 32'h0000_0C01);

        // Drop of the request clears int_req one cycle later.
        cycle(6'h02, 5'd0, 1'b0, 32'h0, 30'h0, 1'b0, 1'b0);
        check("hold_int", 32'(int_req), 32'd1);
        cycle(6'h00, 5'd0, 1'b0, 32'h0, 30'h0, 1'b0, 1'b0);
        check("drop_int", 32'(int_req), 32'd0);

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] ra;
            cycle(6'($urandom), 5'(10 + $urandom_range(0, 7)), ($urandom_range(0, 2) == 0), $urandom,
                  30'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
            check("rand_int_req", 32'(int_req), 32'(model_int()));
            check("rand_epc", epc, m_epc);
            ra = 5'(10 + $urandom_range(0, 7));
            read_check("rand_dout", ra, model_read(ra));
        end

        // Reset asserted mid-service clears state before the next edge.
        cycle(6'h01, 5'd12, 1'b1, 32'h0000_0401, 30'h0, 1'b0, 1'b0);
        cycle(6'h01, 5'd0, 1'b0, 32'h0, 30'h0000_0C02, 1'b1, 1'b0);
        read_check("insvc_sr", 5'd12, 32'h0000_0403);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("midsvc_int_req", 32'(int_req), 32'd0);
        check("midsvc_epc", epc, 32'd0);
        read_check("midsvc_sr", 5'd12, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
